drag_race_reaction_timer: RTL and testbench

Lane-side counterpart to the drag-race light tree. It consumes the green light and the racer's start-beam signal, then reports either a reaction time in milliseconds or a false start. On a false start it drives the red light `R` back to the tree. One instance sits per lane, beside the tree timer, sharing the tree's enable as `Arm`.

---
 rtl/drag_race_pkg.sv | 37 +++
 rtl/rt_bin2bcd.sv | 66 ++++++
 rtl/drag_race_reaction_timer.sv | 186 ++++++++++++++++++
 tb/tb_drag_race_reaction_timer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/drag_race_pkg.sv
// Shared types and constants for the drag-race light tree and lane reaction timers.
package drag_race_pkg;

  localparam int unsigned RT_W       = 14;
  localparam int unsigned RT_MAX_DEF = 9999;
  localparam int unsigned CLK_HZ     = 50_000_000;

  // BCD display width for the lane readout
  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  // Light-tree sequencing constants shared with the tree timer
  localparam int unsigned AMBER_STEP_MS = 500;
  localparam int unsigned PRO_TREE_MS   = 400;
  localparam int unsigned STAGE_HOLD_MS = 600;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    TIMING = 3'd2,
    DONE   = 3'd3,
    FOUL   = 3'd4
  } race_state_e;

  // Double-dabble correction: add 3 to every digit that is 5 or more
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rt_bin2bcd.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add double dabble).
// start loads the operand; done pulses for one cycle after the last of RT_W shifts.
module rt_bin2bcd
  import drag_race_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RT_W-1:0]  bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned CNT_W = $clog2(RT_W + 1);

  logic [RT_W-1:0]  bin_q,  bin_d;
  logic [BCD_W-1:0] bcd_q,  bcd_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] adj;

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    adj    = bcd_adjust(bcd_q);
    if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      cnt_d  = CNT_W'(RT_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Adjust digits, then shift the next binary bit into the BCD LSB
      bcd_d = {adj[BCD_W-2:0], bin_q[RT_W-1]};
      bin_d = {bin_q[RT_W-2:0], 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/drag_race_reaction_timer.sv
// Per-lane reaction timer: measures green-to-launch time in ms or flags a false start.
// Optional DRAG_RT_BCD_EN adds the RtBcd readout via a sequential BCD converter.
module drag_race_reaction_timer
  import drag_race_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = 50_000,
  parameter int unsigned RT_MAX     = RT_MAX_DEF
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Arm,
  input  logic            G,
  input  logic            Launch,
  output logic            R,
  output logic            RtValid,
  output logic [RT_W-1:0] RtMs,
  output logic            Busy
`ifdef DRAG_RT_BCD_EN
  ,
  output logic [BCD_W-1:0] RtBcd
`endif
);

  localparam int unsigned     PS_W    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_MS - 1);
  localparam logic [RT_W-1:0] MS_SAT  = RT_W'(RT_MAX);

  race_state_e     state_q, state_d;
  logic            launch_meta_q;
  logic            ls_q;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [RT_W-1:0] ms_q, ms_d;
  logic [RT_W-1:0] rt_ms_q, rt_ms_d;
  logic            rt_valid_q, rt_valid_d;
  logic            r_q, r_d;
  logic            busy_q, busy_d;
  logic            ms_tick;
  logic [RT_W-1:0] ms_inc;
  logic            done_entry;

`ifdef DRAG_RT_BCD_EN
  logic             conv_start_c;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_pend_q, conv_pend_d;
  logic [BCD_W-1:0] rt_bcd_q, rt_bcd_d;
  logic             arm_entry;
`endif

  // Launch is asynchronous to Clock
  always_ff @(posedge Clock) begin
    if (Reset) begin
      launch_meta_q <= 1'b0;
      ls_q          <= 1'b0;
    end else begin
      launch_meta_q <= Launch;
      ls_q          <= launch_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    ps_d       = ps_q;
    ms_d       = ms_q;
    rt_ms_d    = rt_ms_q;
    rt_valid_d = rt_valid_q;
    ms_tick    = (ps_q == PS_LAST);
    ms_inc     = (ms_tick && (ms_q < MS_SAT)) ? ms_q + RT_W'(1) : ms_q;

    case (state_q)
      IDLE: begin
        if (Arm) begin
          state_d    = ARMED;
          rt_valid_d = 1'b0;
          rt_ms_d    = '0;
          ps_d       = '0;
          ms_d       = '0;
        end
      end
      ARMED: begin
        if (!Arm) begin
          state_d = IDLE;
        end else if (ls_q) begin
          state_d = G ? DONE : FOUL;
        end else if (G) begin
          state_d = TIMING;
        end
      end
      TIMING: begin
        if (!Arm) begin
          state_d = IDLE;
        end else begin
          // Latch includes the ms that completes on this edge
          ps_d    = ms_tick ? '0 : ps_q + PS_W'(1);
          ms_d    = ms_inc;
          rt_ms_d = ms_inc;
          if (ls_q) begin
            state_d = DONE;
          end
        end
      end
      DONE, FOUL: begin
        if (!Arm) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    done_entry = (state_q != DONE) && (state_d == DONE);

`ifdef DRAG_RT_BCD_EN
    // Result is published only once the BCD digits are ready
    arm_entry    = (state_q == IDLE) && Arm;
    conv_start_c = done_entry;
    conv_pend_d  = conv_pend_q;
    rt_bcd_d     = rt_bcd_q;
    if (arm_entry) begin
      conv_pend_d = 1'b0;
    end else if (conv_done && conv_pend_q) begin
      rt_valid_d  = 1'b1;
      rt_bcd_d    = conv_bcd;
      conv_pend_d = 1'b0;
    end
    if (conv_start_c) begin
      conv_pend_d = 1'b1;
    end
`else
    if (done_entry) begin
      rt_valid_d = 1'b1;
    end
`endif

    r_d    = (state_d == FOUL);
    busy_d = (state_d == ARMED) || (state_d == TIMING);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      ps_q       <= '0;
      ms_q       <= '0;
      rt_ms_q    <= '0;
      rt_valid_q <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      ms_q       <= ms_d;
      rt_ms_q    <= rt_ms_d;
      rt_valid_q <= rt_valid_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
    end
  end

`ifdef DRAG_RT_BCD_EN
  rt_bin2bcd u_bin2bcd (
    .clk   (Clock),
    .rst   (Reset),
    .start (conv_start_c),
    .bin   (rt_ms_d),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      conv_pend_q <= 1'b0;
      rt_bcd_q    <= '0;
    end else begin
      conv_pend_q <= conv_pend_d;
      rt_bcd_q    <= rt_bcd_d;
    end
  end

  assign RtBcd = rt_bcd_q;
`endif

  assign R       = r_q;
  assign RtValid = rt_valid_q;
  assign RtMs    = rt_ms_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_drag_race_reaction_timer.sv
// Self-checking bench for drag_race_reaction_timer: directed races plus randomized
// green/launch timing, checked against an elapsed-cycle reference model.
module tb_drag_race_reaction_timer;

`ifdef DRAG_RT_BCD_EN
  localparam int CLK_MS = 8;
  localparam int RT_MX  = 1300;
  localparam bit BCD_EN = 1'b1;
`else
  localparam int CLK_MS = 50;
  localparam int RT_MX  = 300;
  localparam bit BCD_EN = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic        Arm;
  logic        G;
  logic        Launch;
  logic        R;
  logic        RtValid;
  logic [13:0] RtMs;
  logic        Busy;
`ifdef DRAG_RT_BCD_EN
  logic [15:0] RtBcd;
`endif

  int n_vec;
  int n_err;

  drag_race_reaction_timer #(
    .CLK_PER_MS (CLK_MS),
    .RT_MAX     (RT_MX)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Arm     (Arm),
    .G       (G),
    .Launch  (Launch),
    .R       (R),
    .RtValid (RtValid),
    .RtMs    (RtMs),
    .Busy    (Busy)
`ifdef DRAG_RT_BCD_EN
    ,
    .RtBcd   (RtBcd)
`endif
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    return {16'd0, 4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // One race: G first sampled at loop edge tg, Launch first sampled at loop edge tl.
  // The FSM sees the synchronized launch two edges later, at edge tl+2.
  task automatic race(input string tag, input int tg, input int tl, input bit chk_sat);
    int n, exp_ms, exp_edge, t_end, rise_r, rise_v;
    bit foul;
    n        = tl + 2 - tg;
    foul     = (n < 0);
    exp_ms   = foul ? 0 : ((n / CLK_MS) > RT_MX ? RT_MX : n / CLK_MS);
    exp_edge = tl + 2 + ((!foul && BCD_EN) ? 15 : 0);
    t_end    = exp_edge + 3;
    if (tg + 3 > t_end) t_end = tg + 3;
    rise_r = -1;
    rise_v = -1;

    @(negedge Clock);
    Arm = 1'b1; G = 1'b0; Launch = 1'b0;
    @(posedge Clock); #1;
    check({tag, "_armed_busy"}, Busy, 1);
    check({tag, "_armed_valid"}, RtValid, 0);

    for (int t = 0; t <= t_end; t++) begin
      @(negedge Clock);
      G      = (t >= tg);
      Launch = (t >= tl);
      @(posedge Clock); #1;
      if (R && rise_r < 0) rise_r = t;
      if (RtValid && rise_v < 0) rise_v = t;
      if (chk_sat && t == tl - 1) begin
        check({tag, "_sat_live_ms"}, RtMs, RT_MX);
        check({tag, "_sat_busy"}, Busy, 1);
      end
    end

    if (foul) begin
      check({tag, "_r_rise_edge"}, rise_r, tl + 2);
      check({tag, "_r_held"}, R, 1);
      check({tag, "_valid_never"}, rise_v, -1);
      check({tag, "_busy"}, Busy, 0);
    end else begin
      check({tag, "_valid_rise_edge"}, rise_v, exp_edge);
      check({tag, "_ms"}, RtMs, exp_ms);
      check({tag, "_r_never"}, rise_r, -1);
      check({tag, "_busy"}, Busy, 0);
`ifdef DRAG_RT_BCD_EN
      check({tag, "_bcd"}, {16'd0, RtBcd}, to_bcd(exp_ms));
`endif
    end

    @(negedge Clock);
    Arm = 1'b0; G = 1'b0; Launch = 1'b0;
    @(posedge Clock); #1;
    check({tag, "_disarm_r"}, R, 0);
    check({tag, "_disarm_valid_kept"}, RtValid, foul ? 0 : 1);
    repeat (4) @(negedge Clock);
  endtask

  initial begin
    int tg, tl, kind;
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1; Arm = 1'b0; G = 1'b0; Launch = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_r", R, 0);
    check("rst_valid", RtValid, 0);
    check("rst_ms", RtMs, 0);
    check("rst_busy", Busy, 0);
`ifdef DRAG_RT_BCD_EN
    check("rst_bcd", {16'd0, RtBcd}, 0);
`endif
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);

    race("normal", 100, 100 + CLK_MS * 237, 1'b0);
    race("foul", 40, 10, 1'b0);
    race("simul", 20, 18, 1'b0);
    race("ms_edge_lo", 10, 10 - 2 + CLK_MS - 1, 1'b0);
    race("ms_edge_hi", 10, 10 - 2 + CLK_MS, 1'b0);
    race("sat", 5, 5 + CLK_MS * (RT_MX + 5), 1'b1);
`ifdef DRAG_RT_BCD_EN
    race("bcd1234", 10, 10 - 2 + CLK_MS * 1234, 1'b0);
`endif

    // Abort mid-timing
    @(negedge Clock);
    Arm = 1'b1;
    repeat (3) @(negedge Clock);
    G = 1'b1;
    repeat (CLK_MS * 3) @(negedge Clock);
    check("abort_pre_busy", Busy, 1);
    Arm = 1'b0;
    @(posedge Clock); #1;
    check("abort_busy", Busy, 0);
    check("abort_valid", RtValid, 0);
    check("abort_r", R, 0);
    @(negedge Clock);
    G = 1'b0;
    repeat (4) @(negedge Clock);

    // Reset while in FOUL
    Arm = 1'b1;
    repeat (2) @(negedge Clock);
    Launch = 1'b1;
    repeat (5) @(negedge Clock);
    check("rstfoul_pre_r", R, 1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("rstfoul_r", R, 0);
    check("rstfoul_busy", Busy, 0);
    @(negedge Clock);
    Reset = 1'b0; Arm = 1'b0; Launch = 1'b0;
    repeat (4) @(negedge Clock);

    race("rearm", 7, 7 + CLK_MS * 12 + 3, 1'b0);

    for (int i = 0; i < 10; i++) begin
      tg   = int'($urandom_range(30, 3));
      kind = int'($urandom_range(3, 0));
      case (kind)
        0:       tl = int'($urandom_range(tg - 3, 0));
        1:       tl = tg - 2;
        default: tl = tg - 2 + int'($urandom_range(CLK_MS * 20, 1));
      endcase
      race($sformatf("rnd%0d", i), tg, tl, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
